load_store_unit: RTL and testbench
==================================

# load_store_unit

Sits between the MEM pipeline stage and `data_memory`, converting RV32IM loads and stores into word-only memory transactions. Handles the LB/LH/LW/LBU/LHU load formats with extension, and SB/SH/SW stores, using read-modify-write for sub-word stores. Drives the memory's level-held req/valid handshake and stalls the pipeline until each access completes. Misaligned and out-of-range accesses are flagged without touching memory.

## Interface
- `ADDR_WIDTH`, 12: byte-address width of data memory; word index is `addr[ADDR_WIDTH-1:2]`.
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high.
- `lsu_read` in 1: load request; held by pipeline while `lsu_stall`=1.
- `lsu_write` in 1: store request; wins if both requests are high.
- `lsu_funct3` in 3: 000 B, 001 H, 010 W, 100 BU, 101 HU. BU/HU are valid for loads only.
- `lsu_addr` in 32: byte address.
- `lsu_wdata` in 32: store data; low byte/half used for SB/SH.
- `lsu_stall` out 1: combinational, `(lsu_read|lsu_write) && state!=DONE`.
- `lsu_done` out 1: high exactly in DONE.
- `lsu_rdata` out 32: extended load result; valid in DONE; 0 otherwise.
- `lsu_fault` out 1: misaligned/out-of-range/illegal funct3; valid in DONE.
- `mem_read_req` out 1: to memory, level.
- `mem_write_req` out 1: to memory, level.
- `mem_addr` out ADDR_WIDTH: word-aligned (`[1:0]`=00).
- `mem_write_data` out 32.
- `mem_read_data` in 32: meaningful only while `mem_read_valid`=1.
- `mem_read_valid` in 1: one-cycle pulse.
- `mem_write_back_valid` in 1: one-cycle pulse.

## Operation
- States: IDLE, READ, RMW_READ, WRITE, DONE.
- IDLE: on a request, capture funct3, addr, wdata and the op.
  - If fault: go to DONE with `lsu_fault`=1 and issue no memory request.
  - Else load → READ; SW → WRITE; SB/SH → RMW_READ.
- Fault conditions:
  - H/HU with `addr[0]`=1.
  - W with `addr[1:0]`≠0.
  - `addr[31:ADDR_WIDTH]`≠0.
  - funct3 not in the legal set for the op.
- READ: `mem_read_req = !mem_read_valid`.
  - On valid: extract byte `addr[1:0]` / half `addr[1]` from `mem_read_data`.
  - Sign-extend B/H, zero-extend BU/HU, register into `lsu_rdata`, go to DONE.
- RMW_READ: same request rule.
  - On valid: replace the addressed lane with `wdata[7:0]` / `wdata[15:0]`.
  - Register the merged word as `mem_write_data`, go to WRITE.
- WRITE: `mem_write_req = !mem_write_back_valid`. On valid, go to DONE.
- DONE: `lsu_done`=1 for one cycle, then IDLE. The pipeline advances in this cycle, so the same request is never re-accepted.
- Requests are deasserted combinationally in the valid cycle. The memory then sees req low and clears its counter, so no spurious second access starts.
- At most one memory request is high at any time.
- Reset (any state): next cycle IDLE.
  - All outputs 0: reqs, `mem_addr`, `mem_write_data`, `lsu_rdata`, `lsu_fault`, `lsu_done`.
  - A store interrupted by reset has unspecified memory content. The LSU issues no further access for it.

## Timing
- Cycle c0 = IDLE cycle with the request present.
- Memory latency L (=2) is not a parameter here; completion is handshake-driven.
- Load / SW:
  - Reqs in c1..cL+1; valid in cL+1.
  - DONE in cL+2 (c4 for L=2).
  - Stall = L+2 cycles.
- SB/SH:
  - RMW_READ c1..c3.
  - WRITE c4..c6 (`mem_write_back_valid` in c6).
  - DONE c7.
- Fault: DONE in c1, stall 1 cycle.
- `lsu_rdata`/`lsu_fault` are registered and held stable only during DONE.
- Back-to-back: a new request is accepted in the cycle after DONE.

## Structure
- Shared package `rv32_mem_pkg`:
  - funct3 constants (`F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`).
  - LSU state encoding.
- Sub-module `lsu_align` (combinational):
  - Load lane extract + extension.
  - Store lane merge.
  - Alignment check.
- FSM and handshake live in `load_store_unit`.

## Test plan
Memory word 0x010 preloaded with 0x8642F0A5.
- LW 0x010 → `lsu_rdata`=0x8642F0A5, `lsu_done` at c4, `lsu_stall` high c0..c3, `mem_addr`=0x010.
- LB 0x011 → 0xFFFFFFF0; LBU 0x013 → 0x00000086; LH 0x012 → 0xFFFF8642; LHU 0x010 → 0x0000F0A5.
- SB 0x012 wdata 0x12345677 → read at c1..c3, write c4..c6 with data 0x8677F0A5, done c7. Then LW 0x010 returns 0x8677F0A5.
- LH 0x013 and SW 0x1000 → `lsu_fault`=1 at c1, `mem_read_req`/`mem_write_req` never asserted.
- Reset asserted at c2 of an SH → next cycle all outputs 0, state IDLE; word 0x010 still 0x8642F0A5.
- SW 0x020 0xDEADBEEF immediately followed by LW 0x020 → second request accepted the cycle after DONE, returns 0xDEADBEEF; no cycle with both reqs high.

Source files
------------

// File: rtl/rv32_mem_pkg.sv
// Shared RV32 data-memory definitions: funct3 load/store encodings, LSU state
// encoding and the funct3 legality rule.
package rv32_mem_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   localparam logic [2:0] ST_IDLE     = 3'd0;
   localparam logic [2:0] ST_READ     = 3'd1;
   localparam logic [2:0] ST_RMW_READ = 3'd2;
   localparam logic [2:0] ST_WRITE    = 3'd3;
   localparam logic [2:0] ST_DONE     = 3'd4;

   // Unsigned formats only exist for loads.
   function automatic logic f3_legal(input logic [2:0] funct3, input logic is_store);
      logic ok;
      ok = 1'b0;
      case (funct3)
         F3_B, F3_H, F3_W: ok = 1'b1;
         F3_BU, F3_HU:     ok = !is_store;
         default:          ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane handling for the LSU: load extract/extend, sub-word
// store merge, and alignment/legality check of a funct3 + byte offset.
module lsu_align
   import rv32_mem_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  byte_off,
   input  logic        is_store,
   input  logic [31:0] mem_word,
   input  logic [15:0] store_data,
   output logic [31:0] load_result,
   output logic [31:0] merged_word,
   output logic        misaligned,
   output logic        illegal
);

   logic [7:0]  lane_b;
   logic [15:0] lane_h;

   always_comb begin
      lane_b = mem_word[{byte_off, 3'b000} +: 8];
      lane_h = byte_off[1] ? mem_word[31:16] : mem_word[15:0];

      case (funct3)
         F3_B:    load_result = {{24{lane_b[7]}}, lane_b};
         F3_BU:   load_result = {24'd0, lane_b};
         F3_H:    load_result = {{16{lane_h[15]}}, lane_h};
         F3_HU:   load_result = {16'd0, lane_h};
         default: load_result = mem_word;
      endcase

      merged_word = mem_word;
      if (funct3 == F3_B) begin
         merged_word[{byte_off, 3'b000} +: 8] = store_data[7:0];
      end else if (funct3 == F3_H) begin
         if (byte_off[1]) merged_word[31:16] = store_data;
         else             merged_word[15:0]  = store_data;
      end

      misaligned = (((funct3 == F3_H) || (funct3 == F3_HU)) && byte_off[0]) ||
                   ((funct3 == F3_W) && (byte_off != 2'b00));
      illegal    = !f3_legal(funct3, is_store);
   end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: turns RV32 byte/half/word loads and stores into
// word-only data_memory accesses, using read-modify-write for SB/SH.
module load_store_unit
   import rv32_mem_pkg::*;
#(
   parameter int ADDR_WIDTH = 12
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  lsu_read,
   input  logic                  lsu_write,
   input  logic [2:0]            lsu_funct3,
   input  logic [31:0]           lsu_addr,
   input  logic [31:0]           lsu_wdata,
   output logic                  lsu_stall,
   output logic                  lsu_done,
   output logic [31:0]           lsu_rdata,
   output logic                  lsu_fault,
   output logic                  mem_read_req,
   output logic                  mem_write_req,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [31:0]           mem_write_data,
   input  logic [31:0]           mem_read_data,
   input  logic                  mem_read_valid,
   input  logic                  mem_write_back_valid
);

   // Handshake: a memory request is a level held until its one-cycle valid
   // pulse; the request drops combinationally in that same cycle so the memory
   // never starts a second access. The pipeline holds lsu_read/lsu_write while
   // lsu_stall is high and advances in the single DONE cycle.
   logic [2:0]            state;
   logic [2:0]            funct3_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [15:0]           wdata_q;
   logic                  store_q;

   logic                  in_idle;
   logic [2:0]            sel_funct3;
   logic [1:0]            sel_off;
   logic                  sel_store;
   logic [31:0]           load_result;
   logic [31:0]           merged_word;
   logic                  misaligned;
   logic                  illegal;
   logic                  out_of_range;
   logic                  fault_in;

   // In IDLE the checker looks at the live request; afterwards at the capture.
   assign in_idle      = (state == ST_IDLE);
   assign sel_funct3   = in_idle ? lsu_funct3 : funct3_q;
   assign sel_off      = in_idle ? lsu_addr[1:0] : addr_q[1:0];
   assign sel_store    = in_idle ? lsu_write : store_q;
   assign out_of_range = |lsu_addr[31:ADDR_WIDTH];
   assign fault_in     = misaligned || illegal || out_of_range;

   lsu_align u_align (
      .funct3      (sel_funct3),
      .byte_off    (sel_off),
      .is_store    (sel_store),
      .mem_word    (mem_read_data),
      .store_data  (wdata_q),
      .load_result (load_result),
      .merged_word (merged_word),
      .misaligned  (misaligned),
      .illegal     (illegal)
   );

   assign lsu_stall     = (lsu_read || lsu_write) && (state != ST_DONE);
   assign lsu_done      = (state == ST_DONE);
   assign mem_read_req  = ((state == ST_READ) || (state == ST_RMW_READ)) && !mem_read_valid;
   assign mem_write_req = (state == ST_WRITE) && !mem_write_back_valid;
   assign mem_addr      = {addr_q[ADDR_WIDTH-1:2], 2'b00};

   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= ST_IDLE;
         funct3_q       <= 3'd0;
         addr_q         <= '0;
         wdata_q        <= 16'd0;
         store_q        <= 1'b0;
         lsu_rdata      <= 32'd0;
         lsu_fault      <= 1'b0;
         mem_write_data <= 32'd0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (lsu_read || lsu_write) begin
                  funct3_q <= lsu_funct3;
                  addr_q   <= lsu_addr[ADDR_WIDTH-1:0];
                  wdata_q  <= lsu_wdata[15:0];
                  store_q  <= lsu_write;
                  if (fault_in) begin
                     lsu_fault <= 1'b1;
                     state     <= ST_DONE;
                  end else if (!lsu_write) begin
                     state <= ST_READ;
                  end else if (lsu_funct3 == F3_W) begin
                     mem_write_data <= lsu_wdata;
                     state          <= ST_WRITE;
                  end else begin
                     state <= ST_RMW_READ;
                  end
               end
            end
            ST_READ: begin
               if (mem_read_valid) begin
                  lsu_rdata <= load_result;
                  state     <= ST_DONE;
               end
            end
            ST_RMW_READ: begin
               if (mem_read_valid) begin
                  mem_write_data <= merged_word;
                  state          <= ST_WRITE;
               end
            end
            ST_WRITE: begin
               if (mem_write_back_valid) state <= ST_DONE;
            end
            ST_DONE: begin
               lsu_rdata <= 32'd0;
               lsu_fault <= 1'b0;
               state     <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: a two-cycle-latency data_memory model plus a
// byte-level reference memory that predicts load results, faults and latency.
module tb_load_store_unit;

   localparam int AW    = 12;
   localparam int WORDS = 1 << (AW - 2);

   logic          clk = 1'b0;
   logic          reset;
   logic          lsu_read, lsu_write;
   logic [2:0]    lsu_funct3;
   logic [31:0]   lsu_addr, lsu_wdata;
   logic          lsu_stall, lsu_done, lsu_fault;
   logic [31:0]   lsu_rdata;
   logic          mem_read_req, mem_write_req;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_write_data;
   logic [31:0]   mem_read_data;
   logic          mem_read_valid, mem_write_back_valid;

   int errors = 0;
   int checks = 0;
   int both_cnt = 0;

   logic [31:0] dmem    [WORDS];
   logic [31:0] ref_mem [WORDS];
   int          mcnt;

   load_store_unit #(.ADDR_WIDTH(AW)) dut (
      .clk                  (clk),
      .reset                (reset),
      .lsu_read             (lsu_read),
      .lsu_write            (lsu_write),
      .lsu_funct3           (lsu_funct3),
      .lsu_addr             (lsu_addr),
      .lsu_wdata            (lsu_wdata),
      .lsu_stall            (lsu_stall),
      .lsu_done             (lsu_done),
      .lsu_rdata            (lsu_rdata),
      .lsu_fault            (lsu_fault),
      .mem_read_req         (mem_read_req),
      .mem_write_req        (mem_write_req),
      .mem_addr             (mem_addr),
      .mem_write_data       (mem_write_data),
      .mem_read_data        (mem_read_data),
      .mem_read_valid       (mem_read_valid),
      .mem_write_back_valid (mem_write_back_valid)
   );

   // clock / reset
   always #5 clk = ~clk;

   // data_memory model: req level held two cycles, valid pulses in the third
   always @(posedge clk) begin
      mem_read_valid       <= 1'b0;
      mem_write_back_valid <= 1'b0;
      mem_read_data        <= 32'd0;
      if (mem_read_req) begin
         if (mcnt == 1) begin
            mem_read_valid <= 1'b1;
            mem_read_data  <= dmem[mem_addr[AW-1:2]];
            mcnt           <= 0;
         end else mcnt <= mcnt + 1;
      end else if (mem_write_req) begin
         if (mcnt == 1) begin
            mem_write_back_valid        <= 1'b1;
            dmem[mem_addr[AW-1:2]]      <= mem_write_data;
            mcnt                        <= 0;
         end else mcnt <= mcnt + 1;
      end else mcnt <= 0;
   end

   always @(negedge clk) if (mem_read_req && mem_write_req) both_cnt++;

   // reference model
   function automatic int op_size(input logic [2:0] f3);
      if (f3 == 3'b000 || f3 == 3'b100) return 1;
      if (f3 == 3'b001 || f3 == 3'b101) return 2;
      return 4;
   endfunction

   function automatic logic exp_fault(input logic wr, input logic [2:0] f3, input logic [31:0] a);
      logic legal;
      legal = wr ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
      return !legal || (a >= 32'(1 << AW)) || ((a % op_size(f3)) != 0);
   endfunction

   function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] a);
      logic [31:0] w, v;
      w = ref_mem[(a >> 2) % WORDS];
      v = w >> (8 * (a % 4));
      case (f3)
         3'b000:  return (v[7] ? 32'hFFFFFF00 : 32'h0) | (v & 32'hFF);
         3'b100:  return v & 32'hFF;
         3'b001:  return (v[15] ? 32'hFFFF0000 : 32'h0) | (v & 32'hFFFF);
         3'b101:  return v & 32'hFFFF;
         default: return w;
      endcase
   endfunction

   task automatic ref_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
      logic [31:0] mask;
      int sh;
      sh   = 8 * (a % 4);
      mask = (op_size(f3) == 4) ? 32'hFFFFFFFF :
             (op_size(f3) == 2) ? (32'hFFFF << sh) : (32'hFF << sh);
      ref_mem[(a >> 2) % WORDS] = (ref_mem[(a >> 2) % WORDS] & ~mask) | ((wd << sh) & mask);
   endtask

   // driver: presents one request from c0, holds it until DONE, returns observations
   task automatic run_op(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, output int done_cyc, output int stall_cnt,
                         output logic [31:0] rd, output logic flt, output int rcyc,
                         output int wcyc, output logic [AW-1:0] addr_seen,
                         output logic [31:0] wdata_seen);
      lsu_read = !wr; lsu_write = wr; lsu_funct3 = f3; lsu_addr = a; lsu_wdata = wd;
      done_cyc = -1; stall_cnt = 0; rd = 32'hX; flt = 1'bX; rcyc = 0; wcyc = 0;
      addr_seen = '0; wdata_seen = 32'd0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (lsu_stall) stall_cnt++;
         if (mem_read_req) begin rcyc++; addr_seen = mem_addr; end
         if (mem_write_req) begin wcyc++; addr_seen = mem_addr; wdata_seen = mem_write_data; end
         if (lsu_done) begin done_cyc = k; rd = lsu_rdata; flt = lsu_fault; break; end
         @(posedge clk); #1;
      end
      if (done_cyc >= 0) begin @(posedge clk); #1; end
      lsu_read = 1'b0; lsu_write = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; lsu_read = 0; lsu_write = 0; lsu_funct3 = 0; lsu_addr = 0; lsu_wdata = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++; if ({mem_read_req, mem_write_req, lsu_done, lsu_fault, lsu_stall} !== 5'b0) begin
         errors++; $display("FAIL reset_ctrl: got %b required 00000",
                            {mem_read_req, mem_write_req, lsu_done, lsu_fault, lsu_stall});
      end
      checks++; if (lsu_rdata !== 32'd0 || mem_addr !== '0 || mem_write_data !== 32'd0) begin
         errors++; $display("FAIL reset_data: rdata=%h addr=%h wdata=%h required zeros",
                            lsu_rdata, mem_addr, mem_write_data);
      end
      @(posedge clk); #1; reset = 1'b0;
   endtask

   task automatic test_lw();
      int dc, sc, rc, wc; logic [31:0] rd, wds; logic f; logic [AW-1:0] as;
      run_op(0, 3'b010, 32'h010, 0, dc, sc, rd, f, rc, wc, as, wds);
      checks++; if (rd !== 32'h8642F0A5) begin errors++; $display("FAIL lw_data: got %h required 8642f0a5", rd); end
      checks++; if (dc !== 4) begin errors++; $display("FAIL lw_done_cycle: got %0d required 4", dc); end
      checks++; if (sc !== 4) begin errors++; $display("FAIL lw_stall_cycles: got %0d required 4", sc); end
      checks++; if (as !== 12'h010 || rc !== 2 || wc !== 0) begin
         errors++; $display("FAIL lw_mem: addr=%h rd_req=%0d wr_req=%0d required 010/2/0", as, rc, wc);
      end
   endtask

   task automatic test_loads();
      logic [2:0]  f3s [4] = '{3'b000, 3'b100, 3'b001, 3'b101};
      logic [31:0] ads [4] = '{32'h011, 32'h013, 32'h012, 32'h010};
      logic [31:0] exp [4] = '{32'hFFFFFFF0, 32'h00000086, 32'hFFFF8642, 32'h0000F0A5};
      int dc, sc, rc, wc; logic [31:0] rd, wds; logic f; logic [AW-1:0] as;
      for (int i = 0; i < 4; i++) begin
         run_op(0, f3s[i], ads[i], 0, dc, sc, rd, f, rc, wc, as, wds);
         checks++; if (rd !== exp[i] || f !== 1'b0 || dc !== 4) begin
            errors++; $display("FAIL subword_load f3=%0d addr=%h: got %h fault=%b done=%0d required %h/0/4",
                               f3s[i], ads[i], rd, f, dc, exp[i]);
         end
      end
   endtask

   task automatic test_mid_reset();
      lsu_write = 1; lsu_read = 0; lsu_funct3 = 3'b001; lsu_addr = 32'h010; lsu_wdata = 32'h0000BEEF;
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset = 1'b1; lsu_write = 0;
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      checks++; if ({mem_read_req, mem_write_req, lsu_done, lsu_fault} !== 4'b0 ||
                    lsu_rdata !== 32'd0 || mem_addr !== '0 || mem_write_data !== 32'd0) begin
         errors++; $display("FAIL mid_reset_outputs: req=%b%b done=%b fault=%b rdata=%h addr=%h wdata=%h required zeros",
                            mem_read_req, mem_write_req, lsu_done, lsu_fault, lsu_rdata, mem_addr, mem_write_data);
      end
      checks++; if (dmem[4] !== 32'h8642F0A5) begin
         errors++; $display("FAIL mid_reset_mem: got %h required 8642f0a5", dmem[4]);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_sb();
      int dc, sc, rc, wc; logic [31:0] rd, wds; logic f; logic [AW-1:0] as;
      run_op(1, 3'b000, 32'h012, 32'h12345677, dc, sc, rd, f, rc, wc, as, wds);
      ref_store(3'b000, 32'h012, 32'h12345677);
      checks++; if (dc !== 7 || rc !== 2 || wc !== 2 || f !== 1'b0) begin
         errors++; $display("FAIL sb_timing: done=%0d rd_req=%0d wr_req=%0d fault=%b required 7/2/2/0", dc, rc, wc, f);
      end
      checks++; if (wds !== 32'h8677F0A5) begin errors++; $display("FAIL sb_merge: got %h required 8677f0a5", wds); end
      run_op(0, 3'b010, 32'h010, 0, dc, sc, rd, f, rc, wc, as, wds);
      checks++; if (rd !== 32'h8677F0A5) begin errors++; $display("FAIL sb_readback: got %h required 8677f0a5", rd); end
   endtask

   task automatic test_faults();
      int dc, sc, rc, wc; logic [31:0] rd, wds; logic f; logic [AW-1:0] as;
      run_op(0, 3'b001, 32'h013, 0, dc, sc, rd, f, rc, wc, as, wds);
      checks++; if (f !== 1'b1 || dc !== 1 || sc !== 1 || rc !== 0 || wc !== 0) begin
         errors++; $display("FAIL lh_misaligned: fault=%b done=%0d stall=%0d req=%0d/%0d required 1/1/1/0/0", f, dc, sc, rc, wc);
      end
      run_op(1, 3'b010, 32'h1000, 32'hCAFEF00D, dc, sc, rd, f, rc, wc, as, wds);
      checks++; if (f !== 1'b1 || dc !== 1 || sc !== 1 || rc !== 0 || wc !== 0) begin
         errors++; $display("FAIL sw_out_of_range: fault=%b done=%0d stall=%0d req=%0d/%0d required 1/1/1/0/0", f, dc, sc, rc, wc);
      end
   endtask

   task automatic test_back_to_back();
      int dc, sc, rc, wc; logic [31:0] rd, wds; logic f; logic [AW-1:0] as;
      run_op(1, 3'b010, 32'h020, 32'hDEADBEEF, dc, sc, rd, f, rc, wc, as, wds);
      ref_store(3'b010, 32'h020, 32'hDEADBEEF);
      checks++; if (dc !== 4 || wc !== 2 || rc !== 0 || wds !== 32'hDEADBEEF || as !== 12'h020) begin
         errors++; $display("FAIL b2b_sw: done=%0d req=%0d/%0d data=%h addr=%h required 4/0/2/deadbeef/020", dc, rc, wc, wds, as);
      end
      run_op(0, 3'b010, 32'h020, 0, dc, sc, rd, f, rc, wc, as, wds);
      checks++; if (rd !== 32'hDEADBEEF || dc !== 4) begin
         errors++; $display("FAIL b2b_lw: got %h done=%0d required deadbeef/4", rd, dc);
      end
      checks++; if (both_cnt !== 0) begin errors++; $display("FAIL b2b_both_reqs: got %0d cycles required 0", both_cnt); end
   endtask

   task automatic test_random();
      logic [2:0] legal_f3 [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
      int dc, sc, rc, wc, exp_dc, exp_rc, exp_wc;
      logic [31:0] rd, wds, a, wd, exp_rd; logic f, wr, ef; logic [2:0] f3; logic [AW-1:0] as;
      for (int i = 0; i < 60; i++) begin
         wr = 1'($urandom_range(0, 1));
         f3 = ($urandom_range(0, 9) < 8) ? legal_f3[$urandom_range(0, 4)] : 3'($urandom_range(0, 7));
         a  = ($urandom_range(0, 15) == 0) ? 32'h1000 + $urandom_range(0, 64) : 32'h100 + $urandom_range(0, 31);
         wd = $urandom;
         ef = exp_fault(wr, f3, a);
         exp_rd = exp_load(f3, a);
         exp_dc = ef ? 1 : (wr && op_size(f3) != 4) ? 7 : 4;
         exp_rc = (ef || (wr && op_size(f3) == 4)) ? 0 : 2;
         exp_wc = (ef || !wr) ? 0 : 2;
         run_op(wr, f3, a, wd, dc, sc, rd, f, rc, wc, as, wds);
         if (!ef && wr) ref_store(f3, a, wd);
         checks++; if (f !== ef || dc !== exp_dc || sc !== exp_dc || rc !== exp_rc || wc !== exp_wc) begin
            errors++; $display("FAIL rand_ctrl #%0d wr=%b f3=%0d addr=%h: fault=%b done=%0d stall=%0d req=%0d/%0d required %b/%0d/%0d/%0d/%0d",
                               i, wr, f3, a, f, dc, sc, rc, wc, ef, exp_dc, exp_dc, exp_rc, exp_wc);
         end
         if (!ef && !wr) begin
            checks++; if (rd !== exp_rd) begin
               errors++; $display("FAIL rand_load #%0d f3=%0d addr=%h: got %h required %h", i, f3, a, rd, exp_rd);
            end
         end
      end
   endtask

   task automatic test_final_memory();
      int bad;
      bad = 0;
      for (int i = 0; i < WORDS; i++) if (dmem[i] !== ref_mem[i]) bad++;
      checks++; if (bad !== 0) begin errors++; $display("FAIL final_memory: got %0d differing words required 0", bad); end
      checks++; if (both_cnt !== 0) begin errors++; $display("FAIL both_reqs_total: got %0d cycles required 0", both_cnt); end
   endtask

   initial begin
      mcnt = 0; mem_read_valid = 0; mem_write_back_valid = 0; mem_read_data = 0;
      for (int i = 0; i < WORDS; i++) begin
         dmem[i]    = $urandom;
         ref_mem[i] = dmem[i];
      end
      dmem[4] = 32'h8642F0A5; ref_mem[4] = 32'h8642F0A5;
      test_reset();
      test_lw();
      test_loads();
      test_mid_reset();
      test_sb();
      test_faults();
      test_back_to_back();
      test_random();
      test_final_memory();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
